// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding,
// default geometry and the index-width helper.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // A one-chunk adder still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder. c_msb is the carry into the top
// bit, which the parent uses for signed-overflow detection on the last chunk.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock through one shared ripple
// stage. SEQ_CHUNK_ADDER_SUB_EN adds a 'sub' input selecting A-B.
//
//  state  | meaning
//  S_IDLE | ready for operands, accepts on in_valid
//  S_RUN  | adding chunk idx, carry chained through carry_q
//  S_DONE | result presented, waiting for out_ready
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic             accept, last, carry_init;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             co_chunk, cmsb_chunk;

  assign accept = (state == S_IDLE) && in_valid;
  assign last   = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign a_chunk = a_q[int'(idx)*CHUNK +: CHUNK];

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: invert each B chunk as it is consumed.
  assign b_chunk    = b_q[int'(idx)*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
  assign carry_init = sub ? 1'b1 : cin;

  always_ff @(posedge clk) begin
    if (rst)         sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  assign b_chunk    = b_q[int'(idx)*CHUNK +: CHUNK];
  assign carry_init = cin;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .ci    (carry_q),
    .s     (s_chunk),
    .co    (co_chunk),
    .c_msb (cmsb_chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= carry_init;
      idx     <= '0;
    end else if (state == S_RUN) begin
      sum_q[int'(idx)*CHUNK +: CHUNK] <= s_chunk;
      carry_q <= co_chunk;
      if (last) begin
        cout_q <= co_chunk;
        ovf_q  <= co_chunk ^ cmsb_chunk;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed corner cases plus random
// operands against a plain-arithmetic reference model.
module tb_seq_chunk_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: {ovf, cout, sum} from whole-word arithmetic.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic sb);
    logic [WIDTH-1:0] yy;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             ov;
    yy   = sb ? ~y : y;
    cc   = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(cc);
    ov   = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {ov, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Drives one operation from IDLE through the output handshake and reports what it saw.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                        input logic sv, output int lat, output logic [WIDTH-1:0] s_o,
                        output logic c_o, output logic o_o, output logic post_ok);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = sv;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    lat = -1;
    for (int n = 1; n <= NCHUNK + 8; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    s_o = sum; c_o = cout; o_o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_ok = in_ready && !out_valid && (sum === s_o);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: out_valid=%b in_ready=%b sum=%h, want 0 1 0000",
                 i, out_valid, in_ready, sum);
      end
    end
    total++;
    if (cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: cout=%b ovf=%b, want 0 0", cout, ovf);
    end
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] av [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [WIDTH-1:0] bv [3] = '{16'h4321, 16'h0001, 16'h0000};
    logic             cv [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] es [3] = '{16'h5555, 16'h0000, 16'h8000};
    logic             ec [3] = '{1'b0, 1'b1, 1'b0};
    logic             eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat; logic [WIDTH-1:0] s; logic c, o, p;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], 1'b0, lat, s, c, o, p);
      total++;
      if (lat !== NCHUNK) begin
        bad++;
        $display("FAIL directed_latency %0d: got %0d want %0d", i, lat, NCHUNK);
      end
      total++;
      if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
        bad++;
        $display("FAIL directed_result %0d: sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
      total++;
      if (p !== 1'b1) begin
        bad++;
        $display("FAIL directed_post %0d: not idle with retained sum after handshake", i);
      end
    end
  endtask

  task automatic test_stall;
    logic [WIDTH+1:0] exp;
    bit seen;
    exp = ref_add(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'hA5A5; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < NCHUNK + 8; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stall_wait: out_valid never rose, got 0 want 1");
    end
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== exp) begin
        bad++;
        $display("FAIL stall_hold %0d: v=%b r=%b ovf/cout/sum=%h, want 1 0 %h",
                 i, out_valid, in_ready, {ovf, cout, sum}, exp);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [WIDTH-1:0] s; logic c, o, p;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: v=%b r=%b sum=%h cout=%b ovf=%b, want 0 1 0000 0 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    @(negedge clk) rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, s, c, o, p);
    total++;
    if (lat !== NCHUNK || s !== 16'h0002 || c !== 1'b0 || o !== 1'b0) begin
      bad++;
      $display("FAIL midrun_after: lat=%0d sum=%h cout=%b ovf=%b, want %0d 0002 0 0",
               lat, s, c, o, NCHUNK);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    bit idle;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk);
    gap = -1;
    for (int k = 1; k <= 4 * NCHUNK + 8; k++) begin
      @(negedge clk);
      if (in_ready) begin gap = k; break; end
    end
    total++;
    if (gap !== NCHUNK + 2) begin
      bad++;
      $display("FAIL b2b_gap: accept spacing %0d cycles, want %0d", gap, NCHUNK + 2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle = 0;
    for (int k = 0; k < 4 * NCHUNK + 8; k++) begin
      @(posedge clk); #1;
      if (in_ready) begin idle = 1; break; end
    end
    out_ready = 1'b0;
    total++;
    if (!idle || sum !== 16'h3333 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: idle=%b sum=%h out_valid=%b, want 1 3333 0", idle, sum, out_valid);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] av, bv, s;
    logic             cv, sv, c, o, p;
    logic [WIDTH+1:0] exp;
    int lat;
    for (int i = 0; i < 60; i++) begin
      av = WIDTH'($urandom); bv = WIDTH'($urandom); cv = 1'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      sv = 1'($urandom);
`else
      sv = 1'b0;
`endif
      if (i == 0) begin av = '1; bv = '1; cv = 1'b1; end
      exp = ref_add(av, bv, cv, sv);
      run_op(av, bv, cv, sv, lat, s, c, o, p);
      total++;
      if (lat !== NCHUNK || {o, c, s} !== exp || p !== 1'b1) begin
        bad++;
        $display("FAIL random %0d: a=%h b=%h cin=%b sub=%b lat=%0d ovf/cout/sum=%h post=%b, want lat=%0d %h post=1",
                 i, av, bv, cv, sv, lat, {o, c, s}, p, NCHUNK, exp);
      end
    end
  endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub;
    int lat; logic [WIDTH-1:0] s; logic c, o, p;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, s, c, o, p);
    total++;
    if (s !== 16'hFFFE || c !== 1'b0 || o !== 1'b0) begin
      bad++;
      $display("FAIL sub_basic: sum=%h cout=%b ovf=%b, want FFFE 0 0", s, c, o);
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, s, c, o, p);
    total++;
    if (s !== 16'h7FFF || c !== 1'b1 || o !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, want 7FFF 1 1", s, c, o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
